des_round_ctrl: RTL

Iterative DES/3DES round sequencer. Accepts a 64-bit block over a valid/ready handshake, applies the Initial Permutation, drives sixteen Feistel rounds through an external f-function and key-schedule interface, applies the Final Permutation (IP⁻¹), and returns the result over a second valid/ready handshake. It sits between the cipher's block-level data path and the shared f-function/subkey logic. One block is in flight at a time.

---
 rtl/des_round_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES round sequencer.
// Takes one 64-bit block at a time and applies IP. It then runs sixteen Feistel
// rounds through an external f-function and subkey source, applies IP^-1, and
// returns the result.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake; in_data, in_decrypt sampled on accept
//   out_valid/out_ready       output handshake; out_data held until taken
//   round_idx, f_r            subkey index and R half presented to the f-function
//   f_result                  f(f_r, K[round_idx]); combinational (F_LAT=0) or one cycle late (F_LAT=1)
//   busy                      a block is in flight
module des_round_ctrl #(
  parameter int unsigned F_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  round_idx,
  output logic [31:0] f_r,
  input  logic [31:0] f_result,
  output logic        busy
);

  localparam int unsigned W_BLK  = 64;
  localparam int unsigned W_HALF = 32;
  localparam int unsigned W_IDX  = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // FIPS 46-3 tables: output bit i+1 takes input bit TBL[i] (bit 1 = MSB).
  localparam int unsigned IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [W_BLK-1:0] ip_perm(input logic [W_BLK-1:0] din);
    logic [W_BLK-1:0] dout;
    dout = '0;
    for (int i = 0; i < 64; i++) begin
      dout[6'(63 - i)] = din[6'(64 - IP_TBL[i])];
    end
    return dout;
  endfunction

  function automatic logic [W_BLK-1:0] fp_perm(input logic [W_BLK-1:0] din);
    logic [W_BLK-1:0] dout;
    dout = '0;
    for (int i = 0; i < 64; i++) begin
      dout[6'(63 - i)] = din[6'(64 - FP_TBL[i])];
    end
    return dout;
  endfunction

  state_t             state;
  logic [W_HALF-1:0]  l;
  logic [W_HALF-1:0]  r;
  logic [W_IDX-1:0]   cnt;
  logic               stall;
  logic               mode;

  logic [W_BLK-1:0]   ip_in;
  logic [W_HALF-1:0]  r_new;
  logic [W_BLK-1:0]   fp_out;

  assign ip_in  = ip_perm(in_data);
  assign r_new  = l ^ f_result;
  // Final round output is swapped ({R16, L16}) before IP^-1; L16 is the old R.
  assign fp_out = fp_perm({r_new, r});

  assign f_r      = r;
  assign in_ready = (state == IDLE) && !rst;

  // Sequencer: accept, sixteen round steps, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      l         <= '0;
      r         <= '0;
      cnt       <= '0;
      stall     <= 1'b0;
      mode      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            l         <= ip_in[63:32];
            r         <= ip_in[31:0];
            mode      <= in_decrypt;
            cnt       <= '0;
            stall     <= 1'b0;
            round_idx <= in_decrypt ? 4'd15 : 4'd0;
            busy      <= 1'b1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          // With a registered f-function the first cycle of a round only waits.
          if ((F_LAT != 0) && !stall) begin
            stall <= 1'b1;
          end else begin
            stall     <= 1'b0;
            l         <= r;
            r         <= r_new;
            cnt       <= cnt + 4'd1;
            round_idx <= mode ? (round_idx - 4'd1) : (round_idx + 4'd1);
            if (cnt == 4'd15) begin
              out_data  <= fp_out;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
